seq_shifter: RTL and testbench
==============================

SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data width in bits; legal values are powers of two, 2..64.
REQ-002 SHALL provide parameter STEP, default 1, maximum bit positions shifted per cycle; legal values are 1, 2, 4, 8, and STEP <= WIDTH.
REQ-003 SHALL derive localparam SHW = $clog2(WIDTH), the shift-amount width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-007 SHALL have port op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-008 SHALL have port in1  input  WIDTH  operand to shift.
REQ-009 SHALL have port in2  input  SHW  shift amount, 0..WIDTH-1.
REQ-010 SHALL have port out  output  WIDTH  working/result register.
REQ-011 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse; out valid while high.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 SHALL, in IDLE with start=1, load data_r=in1, cnt=in2, op_r=op; next state SHIFT if in2!=0, else DONE.
REQ-015 SHALL ignore start in IDLE-exit cycles, SHIFT and DONE; the in-flight operation and latched op/in1/in2 are unaffected.
REQ-016 SHALL, in each SHIFT cycle, shift data_r by s = min(STEP, cnt) per op_r and set cnt = cnt - s; next state DONE when cnt - s == 0, else stay SHIFT.
REQ-017 SHALL, per shift: SLL fills zeros at LSB; SRL fills zeros at MSB; SRA replicates data_r[WIDTH-1] into the vacated MSBs; ROR moves the s LSBs to the MSBs.
REQ-018 SHALL, in DONE, drive done=1 for exactly one cycle, then go to IDLE.
REQ-019 SHALL drive out = data_r continuously; the result holds in IDLE until the next accepted start.
REQ-020 SHALL give start-to-done latency ceil(in2/STEP)+1 cycles: done is high in the cycle after that many rising edges following the start edge; in2=0 gives 1.
REQ-021 SHALL accept a new start in the cycle immediately after done (back-to-back throughput = latency + 0 idle cycles).
REQ-022 SHALL make the result equal the combinational single-step equivalent: SRA by k = signed in1 >>> k; ROR by k = {in1[k-1:0], in1[WIDTH-1:k]}.
REQ-023 SHALL keep cnt at SHW bits; it never underflows, because s <= cnt.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, set state=IDLE, data_r=0 (out=0), cnt=0, op_r=00, busy=0, done=0.
REQ-025 SHALL let rst override start and any in-progress SHIFT/DONE; no done pulse is produced for the aborted operation.
REQ-026 SHALL accept start on the first edge after rst deasserts.

Verification
REQ-027 WIDTH=32, STEP=1, op=10, in1=0x80000010, in2=4 -> done on the 5th cycle after start, out=0xF8000001, busy high for 5 cycles.
REQ-028 Same in1/in2 with op=01 -> out=0x08000001; with op=00, in1=0x00000001, in2=31 -> out=0x80000000, done after 32 cycles.
REQ-029 op=11, in1=0x00000001, in2=1 -> out=0x80000000; in2=0 with any op, in1=0x12345678 -> out=0x12345678, done 1 cycle after start.
REQ-030 STEP=4, op=10, in1=0x80000000, in2=5 -> 2 SHIFT cycles (4, then 1), done after 3 cycles, out=0xFC000000.
REQ-031 Start pulsed with a different in1 mid-SHIFT -> ignored, original result produced; rst asserted mid-SHIFT -> next cycle busy=0, out=0, no done pulse.
REQ-032 Randomised back-to-back ops vs. reference model for WIDTH in {8,32}, STEP in {1,2,4} -> every done matches the model; no done is missed or duplicated.

Source files
------------

// File: rtl/seq_shifter_if.sv
// Request/result bundle for seq_shifter.
// The master drives the request, the slave returns the result and status.
interface seq_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] in1;
    logic [SHW-1:0]   in2;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;

    modport master (
        output start, op, in1, in2,
        input  out, busy, done
    );

    modport slave (
        input  start, op, in1, in2,
        output out, busy, done
    );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROR, up to STEP bit positions per cycle.
// Result stays on out until the next accepted start.
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    seq_shifter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    if ((WIDTH < 2) || (WIDTH > 64) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
        $error("seq_shifter: WIDTH must be a power of two in 2..64");
    end
    if (!((STEP == 1) || (STEP == 2) || (STEP == 4) || (STEP == 8)) || (STEP > WIDTH)) begin : g_bad_step
        $error("seq_shifter: STEP must be 1, 2, 4 or 8 and not exceed WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_nx;
    logic [WIDTH-1:0] stepped;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   cnt_nx;
    logic [SHW-1:0]   amt;
    logic [1:0]       op_r;
    logic [1:0]       op_nx;
    logic             busy;
    logic             done;

    function automatic logic [WIDTH-1:0] shift_k(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input int               k
    );
        logic [WIDTH-1:0] r;
        r = d;
        unique case (op)
            OP_SLL: r = d << k;
            OP_SRL: r = d >> k;
            OP_SRA: r = $signed(d) >>> k;
            OP_ROR: r = (d >> k) | (d << (WIDTH - k));
            default: r = d;
        endcase
        return r;
    endfunction

    // When STEP equals WIDTH it cannot be encoded in SHW bits, but then
    // cnt < STEP always holds and STEP_W is never selected.
    always_comb begin
        amt = STEP_W;
        if (int'(cnt) < STEP) amt = cnt;
    end

    // Small STEP-way mux of constant shifts instead of a full barrel shifter.
    always_comb begin
        stepped = data_r;
        for (int k = 1; k <= STEP; k++) begin
            if (int'(amt) == k) stepped = shift_k(data_r, op_r, k);
        end
    end

    always_comb begin
        state_nx = state;
        data_nx  = data_r;
        cnt_nx   = cnt;
        op_nx    = op_r;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    data_nx  = bus.in1;
                    cnt_nx   = bus.in2;
                    op_nx    = bus.op;
                    state_nx = (bus.in2 != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                data_nx = stepped;
                cnt_nx  = cnt - amt;
                if (cnt == amt) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            data_r <= '0;
            cnt    <= '0;
            op_r   <= '0;
        end else begin
            state  <= state_nx;
            data_r <= data_nx;
            cnt    <= cnt_nx;
            op_r   <= op_nx;
        end
    end

    assign bus.out  = data_r;
    assign bus.busy = busy;
    assign bus.done = done;
endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: directed vectors plus randomised back-to-back traffic
// on three configurations, checked against a one-step reference model.
module tb_seq_shifter;
    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   left [3];

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          cs;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    seq_shifter_if #(.WIDTH(32)) b0 ();
    seq_shifter_if #(.WIDTH(32)) b1 ();
    seq_shifter_if #(.WIDTH(8))  b2 ();

    seq_shifter #(.WIDTH(32), .STEP(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
    seq_shifter #(.WIDTH(32), .STEP(4)) u1 (.clk(clk), .rst(rst), .bus(b1));
    seq_shifter #(.WIDTH(8),  .STEP(2)) u2 (.clk(clk), .rst(rst), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_shift(
        input logic [1:0] op, input logic [63:0] a_in, input int k, input int w
    );
        logic [63:0] m, a, r;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = a_in & m;
        case (op)
            2'd0: r = a << k;
            2'd1: r = a >> k;
            2'd2: begin
                r = a >> k;
                if (a[w-1]) r = r | (m & ~(m >> k));
            end
            default: r = (a >> k) | (a << (w - k));
        endcase
        return r & m;
    endfunction

    function automatic int w_of(input int d);
        return (d == 2) ? 8 : 32;
    endfunction

    function automatic int st_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 4 : 2);
    endfunction

    function automatic bit busy_of(input int d);
        case (d)
            0: return b0.busy;
            1: return b1.busy;
            default: return b2.busy;
        endcase
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic drive(input int d, input bit st, input logic [1:0] op,
                         input logic [63:0] a, input int sh);
        case (d)
            0: begin b0.start = st; b0.op = op; b0.in1 = a[31:0]; b0.in2 = sh[4:0]; end
            1: begin b1.start = st; b1.op = op; b1.in1 = a[31:0]; b1.in2 = sh[4:0]; end
            default: begin b2.start = st; b2.op = op; b2.in1 = a[7:0]; b2.in2 = sh[2:0]; end
        endcase
    endtask

    task automatic push(input int d, input logic [1:0] op, input logic [63:0] a, input int sh);
        exp_t e;
        e.res = ref_shift(op, a, sh, w_of(d));
        e.lat = (sh + st_of(d) - 1) / st_of(d) + 1;
        e.cs  = cyc + 1;
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mon(input int d, input bit dn, input logic [63:0] o);
        exp_t e;
        if (!dn) return;
        if (qsize(d) == 0) begin
            chk($sformatf("d%0d_spurious_done", d), 1, 0);
            return;
        end
        case (d)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        chk($sformatf("d%0d_out", d), o, e.res);
        chk($sformatf("d%0d_latency", d), cyc - e.cs + 1, e.lat);
    endtask

    always @(negedge clk) begin
        mon(0, b0.done, 64'(b0.out));
        mon(1, b1.done, 64'(b1.out));
        mon(2, b2.done, 64'(b2.out));
    end

    task automatic issue(input int d, input logic [1:0] op, input logic [63:0] a, input int sh);
        int t = 0;
        while (busy_of(d) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("d%0d_idle_before_start", d), busy_of(d), 0);
        drive(d, 1'b1, op, a, sh);
        push(d, op, a, sh);
        @(negedge clk);
        drive(d, 1'b0, op, a, sh);
    endtask

    task automatic drain();
        int t = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain", q0.size() + q1.size() + q2.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 2'd0, 64'd0, 0);
        repeat (3) @(negedge clk);
        chk("rst_out0", b0.out, 0);
        chk("rst_busy0", b0.busy, 0);
        chk("rst_done0", b0.done, 0);
        chk("rst_out1", b1.out, 0);
        chk("rst_busy1", b1.busy, 0);
        chk("rst_out2", b2.out, 0);
        chk("rst_done2", b2.done, 0);
        rst = 1'b0;

        issue(0, 2'd2, 64'h8000_0010, 4);
        drain();
        issue(0, 2'd1, 64'h8000_0010, 4);
        drain();
        issue(0, 2'd0, 64'h0000_0001, 31);
        drain();
        issue(0, 2'd3, 64'h0000_0001, 1);
        drain();
        for (int op = 0; op < 4; op++) begin
            issue(0, 2'(op), 64'h1234_5678, 0);
            drain();
        end

        issue(1, 2'd2, 64'h8000_0000, 5);
        issue(1, 2'd3, 64'h1234_5678, 8);
        issue(1, 2'd0, 64'hFFFF_FFFF, 31);
        drain();

        // A second start mid-shift must not disturb the operation in flight.
        issue(0, 2'd1, 64'h0000_00F0, 4);
        drive(0, 1'b1, 2'd0, 64'hFFFF_FFFF, 3);
        repeat (2) @(negedge clk);
        drive(0, 1'b0, 2'd0, 64'd0, 0);
        drain();

        issue(0, 2'd0, 64'h0000_0001, 20);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", b0.busy, 0);
        chk("abort_out", b0.out, 0);
        chk("abort_done", b0.done, 0);
        q0.delete();
        rst = 1'b0;
        issue(0, 2'd3, 64'h0000_0001, 1);
        drain();
        repeat (30) @(negedge clk);

        left[0] = 60;
        left[1] = 60;
        left[2] = 60;
        for (int t = 0; t < 20000 && (left[0] + left[1] + left[2]) > 0; t++) begin
            for (int d = 0; d < 3; d++) begin
                if (!busy_of(d) && left[d] > 0) begin
                    logic [1:0]  op;
                    logic [63:0] a;
                    int          sh;
                    op = 2'($urandom_range(3));
                    a  = {$urandom, $urandom};
                    sh = $urandom_range(w_of(d) - 1);
                    drive(d, 1'b1, op, a, sh);
                    push(d, op, a, sh);
                    left[d]--;
                end else if (busy_of(d)) begin
                    drive(d, 1'($urandom_range(1)), 2'($urandom_range(3)),
                          {$urandom, $urandom}, $urandom_range(w_of(d) - 1));
                end else begin
                    drive(d, 1'b0, 2'd0, 64'd0, 0);
                end
            end
            @(negedge clk);
        end
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 2'd0, 64'd0, 0);
        chk("random_ops_issued", left[0] + left[1] + left[2], 0);
        drain();
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
